// File: rtl/sa_feeder.sv
// Systolic-array feeder: skews operand beats into the array, drives the en/clc wavefront
// and drains stored sums row by row. Define SA_FEEDER_STATS_EN for stall_cnt/tile_cycles.

module sa_skew_line #(
  parameter int DW = 8,
  parameter int D  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [D:1][DW-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else if (en) begin
      pipe[1] <= d;
      for (int j = 2; j <= D; j++) pipe[j] <= pipe[j-1];
    end
  end

  assign q = pipe[D];
endmodule

module sa_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ROW    = 16,
  parameter int NUM_COL    = 16,
  parameter int K_MAX      = 16,
  parameter int PE_LAT     = 1,
  localparam int DW        = DATA_WIDTH,
  localparam int KW        = $clog2(K_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KW-1:0]                k_len,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [NUM_ROW*DW-1:0]        a_col,
  input  logic [NUM_COL*DW-1:0]        b_row,
  output logic                         en,
  output logic [NUM_ROW:1][DW-1:0]     row_in,
  output logic [NUM_COL:1][DW-1:0]     col_in,
  output logic [NUM_ROW:1][NUM_COL:1]  clc,
  output logic [NUM_ROW:1]             row_out_valid,
  input  logic [NUM_COL:1][DW-1:0]     row_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [NUM_COL*DW-1:0]        res_data,
  output logic                         res_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err
`ifdef SA_FEEDER_STATS_EN
  ,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  tile_cycles
`endif
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam int FLUSH_N = NUM_ROW + NUM_COL - 2 + PE_LAT;
  localparam int FW      = $clog2(FLUSH_N + 1);

  logic [1:0]                state;
  logic [KW-1:0]             k_len_q, beat_cnt;
  logic [FW-1:0]             flush_cnt;
  logic [NUM_ROW:1]          sel;
  logic                      start_ok, feeding, last_beat, res_hs;
  logic [NUM_ROW:1][DW-1:0]  a_in;
  logic [NUM_COL:1][DW-1:0]  b_in;

  assign start_ok  = start && (k_len != '0) && (k_len <= KW'(K_MAX));
  assign feeding   = (state == S_FEED) && op_valid;
  assign op_ready  = (state == S_FEED);
  assign en        = feeding || (state == S_FLUSH);
  assign last_beat = feeding && (beat_cnt == k_len_q - KW'(1));
  assign busy      = (state != S_IDLE);

  // Outside an accepted beat the lines fill with zeros, which is what flushes them.
  assign a_in = feeding ? a_col : '0;
  assign b_in = feeding ? b_row : '0;

  assign res_valid     = (state == S_DRAIN);
  assign res_hs        = res_valid && res_ready;
  assign res_data      = row_out;
  assign res_last      = res_valid && sel[1];
  assign row_out_valid = sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      sel       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            k_len_q  <= k_len;
            beat_cnt <= '0;
            state    <= S_FEED;
          end else if (start) err <= 1'b1;
        end
        S_FEED: begin
          if (last_beat) begin
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end else if (feeding) beat_cnt <= beat_cnt + KW'(1);
        end
        S_FLUSH: begin
          if (flush_cnt == FW'(FLUSH_N - 1)) begin
            sel          <= '0;
            sel[NUM_ROW] <= 1'b1;
            state        <= S_DRAIN;
          end else flush_cnt <= flush_cnt + FW'(1);
        end
        default: begin
          // sel shifts out to zero on the row-1 handshake, so it is idle-clean.
          if (res_hs) begin
            sel <= sel >> 1;
            if (sel[1]) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  for (genvar r = 1; r <= NUM_ROW; r++) begin : g_row
    if (r == NUM_ROW) begin : g_thru
      assign row_in[r] = a_in[r];
    end else begin : g_dly
      sa_skew_line #(.DW(DW), .D(NUM_ROW - r)) u_skew (
        .clk(clk), .rst(rst), .en(en), .d(a_in[r]), .q(row_in[r]));
    end
  end

  for (genvar c = 1; c <= NUM_COL; c++) begin : g_col
    if (c == NUM_COL) begin : g_thru
      assign col_in[c] = b_in[c];
    end else begin : g_dly
      sa_skew_line #(.DW(DW), .D(NUM_COL - c)) u_skew (
        .clk(clk), .rst(rst), .en(en), .d(b_in[c]), .q(col_in[c]));
    end
  end

  // Wavefront: PE(r,c) fires T en-cycles after the last beat; after that beat every cycle is an en-cycle.
  for (genvar r = 1; r <= NUM_ROW; r++) begin : g_clc_r
    for (genvar c = 1; c <= NUM_COL; c++) begin : g_clc_c
      localparam int T = (NUM_ROW - r) + (NUM_COL - c) + PE_LAT;
      if (T == 0) begin : g_now
        assign clc[r][c] = last_beat;
      end else begin : g_wave
        assign clc[r][c] = (state == S_FLUSH) && (flush_cnt == FW'(T - 1));
      end
    end
  end

`ifdef SA_FEEDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= '0;
      tile_cycles <= '0;
    end else if (state == S_IDLE && start_ok) begin
      stall_cnt   <= '0;
      tile_cycles <= '0;
    end else begin
      if (state == S_FEED && !op_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (state != S_IDLE && tile_cycles != '1) tile_cycles <= tile_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder (4x4, DW=8, PE_LAT=1): literal checkpoints plus a per-cycle
// model that predicts outputs from en-cycle history of fed beats.
module tb_sa_feeder;
  logic              clk, rst, start, op_valid, op_ready, en;
  logic [4:0]        k_len;
  logic [31:0]       a_col, b_row, res_data;
  logic [4:1][7:0]   row_in, col_in, row_out;
  logic [4:1][4:1]   clc;
  logic [4:1]        row_out_valid;
  logic              res_valid, res_ready, res_last, busy, done, err;
`ifdef SA_FEEDER_STATS_EN
  logic [31:0]       stall_cnt, tile_cycles;
`endif

  int errors = 0;
  int checks = 0;

  sa_feeder #(.DATA_WIDTH(8), .NUM_ROW(4), .NUM_COL(4), .K_MAX(16), .PE_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .op_valid(op_valid), .op_ready(op_ready), .a_col(a_col), .b_row(b_row),
    .en(en), .row_in(row_in), .col_in(col_in), .clc(clc),
    .row_out_valid(row_out_valid), .row_out(row_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy), .done(done), .err(err)
`ifdef SA_FEEDER_STATS_EN
    , .stall_cnt(stall_cnt), .tile_cycles(tile_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array stand-in: the selected row r returns r*16+c in column c.
  always_comb begin
    row_out = '0;
    for (int r = 1; r <= 4; r++)
      for (int c = 1; c <= 4; c++)
        if (row_out_valid[r]) row_out[c] = 8'(r * 16 + c);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int b, input int mode);
    for (int r = 1; r <= 4; r++) begin
      a_col[r*8-1 -: 8] = (mode != 0) ? 8'((b + 1) | (r << 4)) : 8'(b + 1);
      b_row[r*8-1 -: 8] = (mode != 0) ? 8'(8'h80 | (r << 4) | (b + 1)) : 8'(b + 1);
    end
  endtask

  task automatic wait_done(input string name, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic run_tile(input int k, input int mode);
    start = 1'b1; k_len = 5'(k);
    tick();
    start = 1'b0; op_valid = 1'b1;
    for (int b = 0; b < k; b++) begin
      if (b > 0) tick();
      set_beat(b, mode);
    end
    tick();
    op_valid = 1'b0; a_col = '0; b_row = '0;
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_FEED = 1, M_FLUSH = 2, M_DRAIN = 3;
  int m_mode = M_IDLE, m_k = 0, m_beats = 0, m_fl = 0, m_drow = 0, m_n = 0, m_L = -100;
  int m_stall = 0, m_tile = 0;
  bit m_done = 1'b0, m_err = 1'b0;
  logic [7:0] hist_a [1:4][0:4095];
  logic [7:0] hist_b [1:4][0:4095];

  always @(negedge clk) begin : model
    logic [4:1][7:0] ca, cb, er, ec;
    logic [4:1][4:1] eclc;
    logic [4:1]      erov;
    logic            e_en, e_feed;
    int              d;
    if (rst) begin
      chk("m_rst_en", en, 0);            chk("m_rst_op_ready", op_ready, 0);
      chk("m_rst_busy", busy, 0);        chk("m_rst_clc", clc, 0);
      chk("m_rst_row_out_valid", row_out_valid, 0);
      chk("m_rst_res_valid", res_valid, 0); chk("m_rst_res_last", res_last, 0);
      chk("m_rst_done", done, 0);        chk("m_rst_err", err, 0);
      chk("m_rst_row_in", row_in, 0);    chk("m_rst_col_in", col_in, 0);
      m_mode = M_IDLE; m_n = 0; m_L = -100; m_done = 1'b0; m_err = 1'b0;
      m_stall = 0; m_tile = 0;
    end else begin
      e_feed = (m_mode == M_FEED) && op_valid;
      e_en   = e_feed || (m_mode == M_FLUSH);
      for (int r = 1; r <= 4; r++) begin
        ca[r] = e_feed ? a_col[r*8-1 -: 8] : 8'h0;
        cb[r] = e_feed ? b_row[r*8-1 -: 8] : 8'h0;
      end
      // A lane delayed d en-cycles shows the value fed d en-cycles ago.
      for (int r = 1; r <= 4; r++) begin
        d = 4 - r;
        er[r] = (d == 0) ? ca[r] : ((m_n >= d) ? hist_a[r][m_n-d] : 8'h0);
        ec[r] = (d == 0) ? cb[r] : ((m_n >= d) ? hist_b[r][m_n-d] : 8'h0);
      end
      for (int r = 1; r <= 4; r++)
        for (int c = 1; c <= 4; c++)
          eclc[r][c] = e_en && (m_n == m_L + (4 - r) + (4 - c) + 1);
      erov = (m_mode == M_DRAIN) ? (4'b1000 >> m_drow) : 4'b0000;

      chk("m_en", en, e_en);
      chk("m_op_ready", op_ready, m_mode == M_FEED);
      chk("m_busy", busy, m_mode != M_IDLE);
      chk("m_row_in", row_in, er);
      chk("m_col_in", col_in, ec);
      chk("m_clc", clc, eclc);
      chk("m_row_out_valid", row_out_valid, erov);
      chk("m_res_valid", res_valid, m_mode == M_DRAIN);
      chk("m_res_last", res_last, (m_mode == M_DRAIN) && (m_drow == 3));
      if (m_mode == M_DRAIN) chk("m_res_data", res_data, row_out);
      chk("m_done", done, m_done);
      chk("m_err", err, m_err);
`ifdef SA_FEEDER_STATS_EN
      chk("m_stall_cnt", stall_cnt, m_stall);
      chk("m_tile_cycles", tile_cycles, m_tile);
`endif

      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_mode != M_IDLE) m_tile++;
      case (m_mode)
        M_IDLE:
          if (start) begin
            if (k_len >= 1 && k_len <= 16) begin
              m_k = int'(k_len); m_beats = 0; m_mode = M_FEED; m_stall = 0; m_tile = 0;
            end else m_err = 1'b1;
          end
        M_FEED:
          if (op_valid) begin
            m_beats++;
            if (m_beats == m_k) begin m_L = m_n; m_mode = M_FLUSH; m_fl = 0; end
          end else m_stall++;
        M_FLUSH: begin
          m_fl++;
          if (m_fl == 7) begin m_mode = M_DRAIN; m_drow = 0; end
        end
        default:
          if (res_ready) begin
            m_drow++;
            if (m_drow == 4) begin m_mode = M_IDLE; m_done = 1'b1; end
          end
      endcase
      if (e_en) begin
        for (int r = 1; r <= 4; r++) begin
          hist_a[r][m_n] = ca[r];
          hist_b[r][m_n] = cb[r];
        end
        m_n++;
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; op_valid = 1'b0;
    a_col = '0; b_row = '0; res_ready = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_row_out_valid", row_out_valid, 0);
    tick(); rst = 1'b0;
    tick();

    // Tile 1: k=3, no stalls, res_ready low for the first 5 DRAIN cycles.
    start = 1'b1; k_len = 5'd3;
    tick();
    start = 1'b0; op_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) tick();
      set_beat(b, 0);
      @(negedge clk);
      chk("t1_row_in4", row_in[4], b + 1);
      chk("t1_col_in4", col_in[4], b + 1);
    end
    tick();                                  // cycle 3
    op_valid = 1'b0; a_col = '0; b_row = '0;
    @(negedge clk);
    chk("t1_row_in1_c3", row_in[1], 1);
    chk("t1_col_in1_c3", col_in[1], 1);
    chk("t1_clc44_c3", clc, 16'h8000);
    repeat (6) tick();                       // cycle 9
    @(negedge clk);
    chk("t1_clc11_c9", clc, 16'h0001);
    tick();                                  // cycle 10, DRAIN
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk("t1_hold_rov", row_out_valid, 4'b1000);
      chk("t1_hold_data", res_data, 32'h44434241);
    end
    tick();
    res_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      @(negedge clk);
      chk("t1_drain_rov", row_out_valid, 4'b1000 >> j);
      chk("t1_drain_last", res_last, j == 3);
    end
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_idle", busy, 0);
`ifdef SA_FEEDER_STATS_EN
    chk("t1_tile_cycles", tile_cycles, 19);
`endif
    tick();
    @(negedge clk);
    chk("t1_done_once", done, 0);

    // Rejected starts.
    start = 1'b1; k_len = 5'd0;
    tick(); start = 1'b0;
    @(negedge clk);
    chk("t2_err_k0", err, 1);
    chk("t2_busy_k0", busy, 0);
    tick();
    start = 1'b1; k_len = 5'd17;
    tick(); start = 1'b0;
    @(negedge clk);
    chk("t2_err_k17", err, 1);
    chk("t2_busy_k17", busy, 0);
    tick();
    @(negedge clk);
    chk("t2_err_once", err, 0);

    // Tile 3: k=3 with 2-cycle stall after beat 0; start during FLUSH ignored.
    start = 1'b1; k_len = 5'd3;
    tick();
    start = 1'b0; op_valid = 1'b1; set_beat(0, 1);
    @(negedge clk); chk("t3_en_c0", en, 1);
    tick(); op_valid = 1'b0;
    @(negedge clk); chk("t3_en_c1", en, 0);
    tick();
    @(negedge clk); chk("t3_en_c2", en, 0);
    tick(); op_valid = 1'b1; set_beat(1, 1);
    tick(); set_beat(2, 1);
    tick();                                  // cycle 5, FLUSH
    op_valid = 1'b0; a_col = '0; b_row = '0;
    start = 1'b1; k_len = 5'd2;
    @(negedge clk);
    chk("t3_clc44_c5", clc, 16'h8000);
    chk("t3_row_in1_c5", row_in[1], 8'h11);
    chk("t3_col_in1_c5", col_in[1], 8'h91);
    tick(); start = 1'b0;
    repeat (5) tick();                       // cycle 11
    res_ready = 1'b1;
    @(negedge clk);
    chk("t3_clc11_c11", clc, 16'h0001);
    chk("t3_busy", busy, 1);
    wait_done("t3_done_seen", 20);
`ifdef SA_FEEDER_STATS_EN
    chk("t3_stall_cnt", stall_cnt, 2);
`endif
    tick();
    res_ready = 1'b0;

    // Tile 4: reset during FLUSH, then a clean tile.
    run_tile(2, 0);                          // now in FLUSH cycle 2
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_en", en, 0);
    chk("t4_rst_row_in", row_in, 0);
    tick(); rst = 1'b0;
    tick();
    @(negedge clk);
    chk("t4_no_done", done, 0);
    res_ready = 1'b1;
    run_tile(3, 1);
    wait_done("t4_done_seen", 30);
`ifdef SA_FEEDER_STATS_EN
    chk("t4_tile_cycles", tile_cycles, 14);
    chk("t4_stall_cnt", stall_cnt, 0);
`endif
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
